load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT_CYC, default 64: the number of cycles to wait for bus_ack_lsu_i before a bus error is declared; legal range 1..255.
REQ-002 clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 req_valid_lsu_i  in  1  the EX stage presents a memory operation.
REQ-005 req_ready_lsu_o  out  1  the unit can accept an operation this cycle.
REQ-006 mem_wr_lsu_i  in  1  1 = store, 0 = load.
REQ-007 funct3_lsu_i  in  3  RISC-V width/sign field: LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101.
REQ-008 addr_lsu_i  in  32  effective byte address.
REQ-009 wdata_lsu_i  in  32  store data (rs2).
REQ-010 rd_lsu_i  in  5  load destination register.
REQ-011 bus_req_lsu_o, bus_we_lsu_o  out  1 each  data-bus request and write enable.
REQ-012 bus_addr_lsu_o  out  32  word-aligned address, addr[31:2],2'b00.
REQ-013 bus_be_lsu_o  out  4  byte enables.
REQ-014 bus_wdata_lsu_o  out  32  lane-replicated store data.
REQ-015 bus_ack_lsu_i  in  1  bus completion for the outstanding request.
REQ-016 bus_rdata_lsu_i  in  32  read data, valid when bus_ack_lsu_i=1.
REQ-017 resp_valid_lsu_o  out  1  one-cycle completion pulse.
REQ-018 resp_data_lsu_o  out  32  extended load data; 0 for stores.
REQ-019 resp_rd_lsu_o  out  5  destination register of the completing operation.
REQ-020 resp_rf_en_lsu_o  out  1  register-file write enable; 1 only for a load with rd!=0.
REQ-021 stall_lsu_o  out  1  pipeline hold; equals the state not being IDLE.
REQ-022 misalign_lsu_o, buserr_lsu_o  out  1 each  one-cycle exception pulses.

Function
REQ-023 The FSM SHALL have the states IDLE, BUS and RESP; req_ready_lsu_o=1 only in IDLE.
REQ-024 An operation is accepted when req_valid_lsu_i and req_ready_lsu_o are both 1; the unit SHALL register mem_wr, funct3, addr, wdata and rd.
REQ-025 An operation is misaligned if it is a halfword with addr[0]=1, a word with addr[1:0]!=00, a load with funct3 in {011,110,111}, or a store with funct3>010.
REQ-026 A misaligned operation SHALL issue no bus request. The unit SHALL pulse misalign_lsu_o in the cycle after acceptance and stay in IDLE.
REQ-027 An aligned operation SHALL move the FSM to BUS. bus_req_lsu_o is asserted from the next cycle, and addr, we, be and wdata SHALL be held stable until ack.
REQ-028 Byte enables: SB = 0001<<addr[1:0]; SH = 0011<<{addr[1],0}; SW = 1111; loads = the same pattern with we=0.
REQ-029 Store data: SB = {4{wdata[7:0]}}; SH = {2{wdata[15:0]}}; SW = wdata.
REQ-030 When bus_ack_lsu_i=1 in BUS, the unit SHALL drop bus_req next cycle, capture rdata and enter RESP.
REQ-031 In RESP the unit SHALL pulse resp_valid_lsu_o for one cycle and return to IDLE.
REQ-032 Total latency: acceptance at cycle N, bus_req at N+1, ack at M>=N+1, resp_valid at M+1, new acceptance possible at M+2.
REQ-033 Load extraction: LB/LBU select byte addr[1:0] with sign/zero extension; LH/LHU select halfword addr[1] with sign/zero extension; LW passes the word through.
REQ-034 A timeout counter SHALL count BUS cycles without ack. When it reaches TIMEOUT_CYC, the unit SHALL drop bus_req, pulse buserr_lsu_o, produce no resp_valid, and return to IDLE.
REQ-035 An ack outside BUS SHALL be ignored. An ack in the same cycle as the timeout SHALL win, and no buserr is raised.

Reset
REQ-036 While reset=1 the FSM SHALL be IDLE, the counter 0, and every output 0 except req_ready_lsu_o=1.
REQ-037 Reset mid-operation SHALL drop bus_req immediately (asynchronously), without a response or exception pulse.

Structure
REQ-038 A shared package riscv_lsu_pkg SHALL hold the funct3 width encodings, the FSM state encoding and the default TIMEOUT_CYC.
REQ-039 The byte-lane logic (be, wdata replication, load extraction) SHALL live in one combinational sub-module, lsu_align.

Verification
REQ-040 SB: addr=0x1003, wdata=0x000000A5 -> bus_be=1000, bus_wdata=0xA5A5A5A5, bus_addr=0x1000, resp_rf_en=0.
REQ-041 LB: addr=0x2001, rd=5, rdata=0x00008000 with ack after 3 cycles -> resp_data=0xFFFFFF80, rf_en=1, resp_valid 4 cycles after the first bus_req cycle.
REQ-042 LHU: addr=0x2002, rdata=0xBEEF1234 -> resp_data=0x0000BEEF. The same sequence with rd=0 -> resp_rf_en=0.
REQ-043 LW: addr=0x3002 -> no bus_req, misalign pulse 1 cycle, req_ready=1 in the following cycle.
REQ-044 No ack with TIMEOUT_CYC=4 -> bus_req high for 4 cycles, a single buserr pulse, no resp_valid.
REQ-045 Reset asserted while in BUS -> bus_req low in the same cycle; after release, a new LW completes normally.

Source files
------------

// File: rtl/riscv_lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 width codes, FSM states,
// default bus timeout and the alignment legality check used at acceptance.
package riscv_lsu_pkg;

    localparam int TIMEOUT_CYC_DEF = 64;
    localparam int TMO_W           = 8;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_e;

    // Illegal width codes are folded into the same exception as bad alignment.
    function automatic logic lsu_misaligned(input logic       wr,
                                            input logic [2:0] f3,
                                            input logic [1:0] off);
        logic bad_f3;
        bad_f3 = wr ? (f3 > F3_W)
                    : (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
        return bad_f3 ||
               (f3[1:0] == F3_H[1:0] && off[0]) ||
               (f3[1:0] == F3_W[1:0] && off != 2'b00);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store byte enables and data replication, and load data
// extraction with sign or zero extension.
module lsu_align
    import riscv_lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ldata_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        sext;

    always_comb begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        case (funct3_i[1:0])
            2'b00: begin
                be_o    = 4'b0001 << off_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                be_o    = off_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
            end
            default: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
            end
        endcase
    end

    always_comb begin
        byte_sel = rdata_i[7:0];
        case (off_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        sext     = ~funct3_i[2];
        case (funct3_i[1:0])
            2'b00:   ldata_o = {{24{sext & byte_sel[7]}}, byte_sel};
            2'b01:   ldata_o = {{16{sext & half_sel[15]}}, half_sel};
            default: ldata_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between the EX stage and a data bus with
// ack handshake, bus timeout and registered exception/response pulses.
module load_store_unit
    import riscv_lsu_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid_lsu_i,
    output logic        req_ready_lsu_o,
    input  logic        mem_wr_lsu_i,
    input  logic [2:0]  funct3_lsu_i,
    input  logic [31:0] addr_lsu_i,
    input  logic [31:0] wdata_lsu_i,
    input  logic [4:0]  rd_lsu_i,
    output logic        bus_req_lsu_o,
    output logic        bus_we_lsu_o,
    output logic [31:0] bus_addr_lsu_o,
    output logic [3:0]  bus_be_lsu_o,
    output logic [31:0] bus_wdata_lsu_o,
    input  logic        bus_ack_lsu_i,
    input  logic [31:0] bus_rdata_lsu_i,
    output logic        resp_valid_lsu_o,
    output logic [31:0] resp_data_lsu_o,
    output logic [4:0]  resp_rd_lsu_o,
    output logic        resp_rf_en_lsu_o,
    output logic        stall_lsu_o,
    output logic        misalign_lsu_o,
    output logic        buserr_lsu_o
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    lsu_state_e       state_q, state_d;
    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic             mem_wr_q, mem_wr_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [4:0]       rd_q, rd_d;
    logic             bus_req_q, bus_req_d;
    logic             resp_valid_q, resp_valid_d;
    logic [31:0]      resp_data_q, resp_data_d;
    logic             rf_en_q, rf_en_d;
    logic             misalign_q, misalign_d;
    logic             buserr_q, buserr_d;

    logic [3:0]       lane_be;
    logic [31:0]      lane_wdata;
    logic [31:0]      lane_ldata;

    lsu_align u_align (
        .funct3_i (funct3_q),
        .off_i    (addr_q[1:0]),
        .wdata_i  (wdata_q),
        .rdata_i  (bus_rdata_lsu_i),
        .be_o     (lane_be),
        .wdata_o  (lane_wdata),
        .ldata_o  (lane_ldata)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mem_wr_d     = mem_wr_q;
        funct3_d     = funct3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rd_d         = rd_q;
        bus_req_d    = bus_req_q;
        resp_data_d  = resp_data_q;
        resp_valid_d = 1'b0;
        rf_en_d      = 1'b0;
        misalign_d   = 1'b0;
        buserr_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_lsu_i) begin
                    mem_wr_d = mem_wr_lsu_i;
                    funct3_d = funct3_lsu_i;
                    addr_d   = addr_lsu_i;
                    wdata_d  = wdata_lsu_i;
                    rd_d     = rd_lsu_i;
                    if (lsu_misaligned(mem_wr_lsu_i, funct3_lsu_i, addr_lsu_i[1:0])) begin
                        misalign_d = 1'b1;
                    end else begin
                        state_d   = ST_BUS;
                        bus_req_d = 1'b1;
                        cnt_d     = '0;
                    end
                end
            end
            ST_BUS: begin
                // Ack is checked first so it wins over a coincident timeout.
                if (bus_ack_lsu_i) begin
                    state_d      = ST_RESP;
                    bus_req_d    = 1'b0;
                    cnt_d        = '0;
                    resp_valid_d = 1'b1;
                    rf_en_d      = ~mem_wr_q & (rd_q != 5'd0);
                    resp_data_d  = mem_wr_q ? 32'd0 : lane_ldata;
                end else if (cnt_q == TMO_LAST) begin
                    state_d   = ST_IDLE;
                    bus_req_d = 1'b0;
                    cnt_d     = '0;
                    buserr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            mem_wr_q     <= 1'b0;
            funct3_q     <= 3'b000;
            addr_q       <= '0;
            wdata_q      <= '0;
            rd_q         <= '0;
            bus_req_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            rf_en_q      <= 1'b0;
            misalign_q   <= 1'b0;
            buserr_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mem_wr_q     <= mem_wr_d;
            funct3_q     <= funct3_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rd_q         <= rd_d;
            bus_req_q    <= bus_req_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            rf_en_q      <= rf_en_d;
            misalign_q   <= misalign_d;
            buserr_q     <= buserr_d;
        end
    end

    // Bus qualifiers are gated by the request flop so they read zero when idle.
    assign bus_req_lsu_o    = bus_req_q;
    assign bus_we_lsu_o     = bus_req_q & mem_wr_q;
    assign bus_addr_lsu_o   = bus_req_q ? {addr_q[31:2], 2'b00} : 32'd0;
    assign bus_be_lsu_o     = bus_req_q ? lane_be : 4'b0000;
    assign bus_wdata_lsu_o  = bus_req_q ? lane_wdata : 32'd0;

    assign req_ready_lsu_o  = (state_q == ST_IDLE);
    assign stall_lsu_o      = (state_q != ST_IDLE);
    assign resp_valid_lsu_o = resp_valid_q;
    assign resp_data_lsu_o  = resp_data_q;
    assign resp_rd_lsu_o    = rd_q;
    assign resp_rf_en_lsu_o = rf_en_q;
    assign misalign_lsu_o   = misalign_q;
    assign buserr_lsu_o     = buserr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a behavioural model of the
// byte-lane, alignment, handshake and timeout rules.
module tb_load_store_unit;

    localparam int TMO = 4;

    logic        clk;
    logic        reset;
    logic        req_valid, req_ready, mem_wr;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic [4:0]  rd;
    logic        bus_req, bus_we, bus_ack;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;
    logic        resp_valid, resp_rf_en, stall, misalign, buserr;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;

    int n_vec = 0;
    int n_err = 0;

    load_store_unit #(.TIMEOUT_CYC(TMO)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid_lsu_i  (req_valid),
        .req_ready_lsu_o  (req_ready),
        .mem_wr_lsu_i     (mem_wr),
        .funct3_lsu_i     (funct3),
        .addr_lsu_i       (addr),
        .wdata_lsu_i      (wdata),
        .rd_lsu_i         (rd),
        .bus_req_lsu_o    (bus_req),
        .bus_we_lsu_o     (bus_we),
        .bus_addr_lsu_o   (bus_addr),
        .bus_be_lsu_o     (bus_be),
        .bus_wdata_lsu_o  (bus_wdata),
        .bus_ack_lsu_i    (bus_ack),
        .bus_rdata_lsu_i  (bus_rdata),
        .resp_valid_lsu_o (resp_valid),
        .resp_data_lsu_o  (resp_data),
        .resp_rd_lsu_o    (resp_rd),
        .resp_rf_en_lsu_o (resp_rf_en),
        .stall_lsu_o      (stall),
        .misalign_lsu_o   (misalign),
        .buserr_lsu_o     (buserr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // ack_dly: index of the bus cycle carrying ack; >= TMO means no ack at all.
    task automatic do_op(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] r,
                         input logic [31:0] rdat, input int ack_dly);
        logic        mis;
        logic [3:0]  ebe;
        logic [31:0] ewd, eld, erd;
        int          sz, off, v;
        sz  = int'(f3[1:0]);
        off = int'(a[1:0]);
        if (wr) mis = (f3 > 3'd2);
        else    mis = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        if (sz == 1 && (off % 2) != 0) mis = 1'b1;
        if (sz == 2 && off != 0)       mis = 1'b1;
        if (sz == 0) begin
            ebe = 4'(1 << off);
            ewd = (wd & 32'hFF) * 32'h01010101;
            v   = int'((rdat >> (8 * off)) & 32'hFF);
            if (!f3[2] && v >= 128) v = v - 256;
        end else if (sz == 1) begin
            ebe = (off >= 2) ? 4'b1100 : 4'b0011;
            ewd = (wd & 32'hFFFF) * 32'h00010001;
            v   = int'((rdat >> (16 * (off / 2))) & 32'hFFFF);
            if (!f3[2] && v >= 32768) v = v - 65536;
        end else begin
            ebe = 4'b1111;
            ewd = wd;
            v   = int'(rdat);
        end
        eld = 32'(v);
        erd = wr ? 32'd0 : eld;

        check_val("ready_before", 32'(req_ready), 32'd1);
        req_valid = 1'b1; mem_wr = wr; funct3 = f3; addr = a; wdata = wd; rd = r;
        next_cycle();
        req_valid = 1'b0; mem_wr = $urandom; funct3 = 3'($urandom); addr = $urandom;
        wdata = $urandom; rd = 5'($urandom);

        if (mis) begin
            check_val("mis_pulse", 32'(misalign), 32'd1);
            check_val("mis_no_req", 32'(bus_req), 32'd0);
            check_val("mis_ready", 32'(req_ready), 32'd1);
            next_cycle();
            check_val("mis_pulse_end", 32'(misalign), 32'd0);
            return;
        end
        for (int k = 0; k < TMO; k++) begin
            check_val("bus_req", 32'(bus_req), 32'd1);
            check_val("bus_addr", bus_addr, a & 32'hFFFFFFFC);
            check_val("bus_be", 32'(bus_be), 32'(ebe));
            check_val("bus_we", 32'(bus_we), 32'(wr));
            if (wr) check_val("bus_wdata", bus_wdata, ewd);
            check_val("bus_stall", 32'(stall), 32'd1);
            check_val("bus_no_ready", 32'(req_ready), 32'd0);
            check_val("bus_no_resp", 32'(resp_valid), 32'd0);
            check_val("bus_no_err", 32'(buserr), 32'd0);
            if (k == ack_dly) begin
                bus_ack = 1'b1; bus_rdata = rdat;
                next_cycle();
                bus_ack = 1'b0; bus_rdata = $urandom;
                check_val("resp_req_drop", 32'(bus_req), 32'd0);
                check_val("resp_valid", 32'(resp_valid), 32'd1);
                check_val("resp_data", resp_data, erd);
                check_val("resp_rd", 32'(resp_rd), 32'(r));
                check_val("resp_rf_en", 32'(resp_rf_en), 32'(!wr && r != 5'd0));
                check_val("resp_no_err", 32'(buserr), 32'd0);
                check_val("resp_ready", 32'(req_ready), 32'd0);
                next_cycle();
                check_val("resp_pulse_end", 32'(resp_valid), 32'd0);
                check_val("resp_ready_after", 32'(req_ready), 32'd1);
                return;
            end
            bus_rdata = $urandom;
            next_cycle();
        end
        check_val("tmo_req_drop", 32'(bus_req), 32'd0);
        check_val("tmo_buserr", 32'(buserr), 32'd1);
        check_val("tmo_no_resp", 32'(resp_valid), 32'd0);
        check_val("tmo_ready", 32'(req_ready), 32'd1);
        next_cycle();
        check_val("tmo_pulse_end", 32'(buserr), 32'd0);
        check_val("tmo_no_resp2", 32'(resp_valid), 32'd0);
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; mem_wr = 1'b0; funct3 = 3'b000;
        addr = '0; wdata = '0; rd = '0; bus_ack = 1'b0; bus_rdata = '0;
        next_cycle();
        check_val("rst_ready", 32'(req_ready), 32'd1);
        check_val("rst_bus_req", 32'(bus_req), 32'd0);
        check_val("rst_bus_out", bus_addr | bus_wdata | 32'(bus_be) | 32'(bus_we), 32'd0);
        check_val("rst_resp", resp_data | 32'(resp_rd) | 32'(resp_valid) | 32'(resp_rf_en), 32'd0);
        check_val("rst_flags", 32'({stall, misalign, buserr}), 32'd0);
        next_cycle();
        reset = 1'b0;
        next_cycle();

        // Directed cases
        do_op(1'b1, 3'b000, 32'h00001003, 32'h000000A5, 5'd7, 32'h0, 0);
        do_op(1'b0, 3'b000, 32'h00002001, 32'h0, 5'd5, 32'h00008000, 3);
        do_op(1'b0, 3'b101, 32'h00002002, 32'h0, 5'd9, 32'hBEEF1234, 1);
        do_op(1'b0, 3'b101, 32'h00002002, 32'h0, 5'd0, 32'hBEEF1234, 1);
        do_op(1'b0, 3'b010, 32'h00003002, 32'h0, 5'd3, 32'h0, 0);
        do_op(1'b0, 3'b010, 32'h00003000, 32'h0, 5'd3, 32'h0, TMO + 2);
        do_op(1'b1, 3'b001, 32'h00000006, 32'h1234ABCD, 5'd1, 32'h0, 2);
        do_op(1'b1, 3'b011, 32'h00000000, 32'h0, 5'd1, 32'h0, 0);

        // Ack while idle must be ignored
        bus_ack = 1'b1;
        next_cycle();
        next_cycle();
        bus_ack = 1'b0;
        check_val("idle_ack_no_resp", 32'(resp_valid), 32'd0);
        check_val("idle_ack_no_stall", 32'(stall), 32'd0);

        // Reset while in BUS
        check_val("pre_rst_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1; mem_wr = 1'b0; funct3 = 3'b010; addr = 32'h00004000; rd = 5'd4;
        next_cycle();
        req_valid = 1'b0;
        check_val("pre_rst_bus_req", 32'(bus_req), 32'd1);
        next_cycle();
        #2 reset = 1'b1;
        #1;
        check_val("async_rst_req", 32'(bus_req), 32'd0);
        check_val("async_rst_ready", 32'(req_ready), 32'd1);
        check_val("async_rst_stall", 32'(stall), 32'd0);
        next_cycle();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            check_val("post_rst_quiet", 32'({resp_valid, misalign, buserr, bus_req}), 32'd0);
        end
        do_op(1'b0, 3'b010, 32'h00004008, 32'h0, 5'd6, 32'hCAFEF00D, 1);

        // Randomized operations
        for (int i = 0; i < 300; i++) begin
            logic [31:0] ra;
            ra = $urandom;
            if ($urandom_range(0, 2) == 0) ra[1:0] = 2'b00;
            do_op(1'($urandom), 3'($urandom), ra, $urandom, 5'($urandom),
                  $urandom, int'($urandom_range(0, TMO + 1)));
            if ($urandom_range(0, 3) == 0) next_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
